// File: rtl/cnn_relu3_flatten_serializer.sv
// Requantizes a 64-lane ReLU vector in one beat and streams
// it out one element per beat; zero-bubble frame chaining.
module cnn_relu3_flatten_serializer #(
  parameter int N_CH  = 64,
  parameter int IN_W  = 48,
  parameter int OUT_W = 16,
  parameter int SHIFT = 16,
  localparam int IW   = $clog2(N_CH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_CH-1:0][IN_W-1:0]  in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_data,
  output logic [IW-1:0]              out_idx,
  output logic                       out_last,
  output logic                       busy,
  output logic [15:0]                frame_cnt
);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  localparam logic [IN_W:0] HALF =
    (IN_W+1)'(1) << (SHIFT-1);
  localparam logic [IN_W:0] QMAX =
    {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic [IW-1:0] LAST_IDX =
    IW'(N_CH-1);

  state_t                         state_q, state_d;
  logic [IW-1:0]                  idx_q, idx_d;
  logic [15:0]                    frame_cnt_q, frame_cnt_d;
  logic [N_CH-1:0][OUT_W-1:0]     buf_q;
  logic                           acc_in, acc_out;
  logic                           at_last;

  // Negative lanes clamp to 0; positive lanes round half-up
  // in IN_W+1 bits, then saturate to the signed output max.
  function automatic logic [OUT_W-1:0] requant(
    input logic [IN_W-1:0] x
  );
    logic [IN_W:0] s;
    logic [IN_W:0] r;
    s = {1'b0, x} + HALF;
    r = s >> SHIFT;
    if (x[IN_W-1])
      return '0;
    else if (r > QMAX)
      return QMAX[OUT_W-1:0];
    else
      return r[OUT_W-1:0];
  endfunction

  // Handshakes, next state, and output decode.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    frame_cnt_d = frame_cnt_q;
    out_valid   = (state_q == STREAM);
    at_last     = (idx_q == LAST_IDX);
    acc_out     = out_valid & out_ready;
    in_ready    = (state_q == IDLE) |
                  (acc_out & at_last);
    acc_in      = in_valid & in_ready;
    unique case (state_q)
      IDLE: begin
        if (acc_in) begin
          state_d = STREAM;
          idx_d   = '0;
        end
      end
      STREAM: begin
        if (acc_out) begin
          if (at_last) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            idx_d       = '0;
            if (!acc_in)
              state_d = IDLE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Frame buffer: all lanes requantized at the accept edge.
  always_ff @(posedge clk) begin
    if (acc_in) begin
      for (int i = 0; i < N_CH; i++)
        buf_q[i] <= requant(in_data[i]);
    end
  end

  assign out_data  = out_valid ? buf_q[idx_q] : '0;
  assign out_idx   = idx_q;
  assign out_last  = out_valid & at_last;
  assign busy      = (state_q == STREAM);
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_cnn_relu3_flatten_serializer.sv
// Randomized scoreboard bench for the layer-3 serializer.
// Driver pushes expected beats; monitor pops on out handshakes.
module tb_cnn_relu3_flatten_serializer;

  localparam int N   = 64;
  localparam int IW  = 48;
  localparam int OW  = 16;
  localparam int XW  = 6;

  typedef logic [N-1:0][IW-1:0] frame_t;
  typedef struct {
    int data;
    int idx;
    bit last;
  } exp_t;

  logic           clk = 0;
  logic           rst = 1;
  logic           in_valid = 0;
  logic           in_ready;
  frame_t         in_data = '0;
  logic           out_valid;
  logic           out_ready = 1;
  logic [OW-1:0]  out_data;
  logic [XW-1:0]  out_idx;
  logic           out_last;
  logic           busy;
  logic [15:0]    frame_cnt;

  int   checks = 0;
  int   errors = 0;
  bit   rnd_ready = 0;
  exp_t q[$];

  cnn_relu3_flatten_serializer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: signed lane, clamp negatives, round half-up
  // by 2^16, saturate at 32767.
  function automatic int model(logic [IW-1:0] v);
    longint x;
    longint r;
    x = longint'(signed'(v));
    if (x < 0) return 0;
    r = (x + 32768) / 65536;
    if (r > 32767) return 32767;
    return int'(r);
  endfunction

  function automatic logic [IW-1:0] rnd_lane();
    longint v;
    case ($urandom % 4)
      0: v = {$urandom, $urandom};
      1: v = longint'($urandom_range(0, 32767)) * 65536
             + $urandom_range(0, 65535);
      2: v = longint'($urandom_range(0, 32768)) * 65536
             + 32767 + $urandom_range(0, 2);
      default: v = -longint'($urandom_range(1, 1000000));
    endcase
    return v[IW-1:0];
  endfunction

  function automatic frame_t rnd_frame();
    frame_t f;
    for (int i = 0; i < N; i++) f[i] = rnd_lane();
    return f;
  endfunction

  task automatic push_frame(frame_t f);
    exp_t e;
    for (int i = 0; i < N; i++) begin
      e.data = model(f[i]);
      e.idx  = i;
      e.last = (i == N - 1);
      q.push_back(e);
    end
  endtask

  task automatic send(input frame_t f,
                      output bit vacc, output int iacc);
    bit ok;
    ok   = 0;
    vacc = 0;
    iacc = -1;
    @(posedge clk); #1;
    in_valid = 1;
    in_data  = f;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (in_ready) begin
        vacc = out_valid;
        iacc = int'(out_idx);
        push_frame(f);
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no in_ready expected 1");
    end
    @(posedge clk); #1;
    in_valid = 0;
    in_data  = rnd_frame();
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int c = 0; c < 5000; c++) begin
      @(posedge clk); #1;
      if (!busy && q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    chk("idle_reached", ok, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
    q.delete();
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      out_ready = rnd_ready ? 1'($urandom % 2) : 1'b1;
    end
  end

  // Monitor: pops on each accepted beat, checks hold on stall.
  initial begin
    bit          pstall;
    logic [15:0] pd;
    logic [5:0]  pi;
    exp_t        e;
    pstall = 0;
    pd = '0;
    pi = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pstall = 0;
        continue;
      end
      if (pstall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, pd);
        chk("hold_idx", out_idx, pi);
      end
      if (!out_valid) chk("zero_data", out_data, 0);
      chk("last_flag", out_last,
          out_valid && out_idx == 6'(N - 1));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_beat: got idx %0d expected none",
                   out_idx);
        end else begin
          e = q.pop_front();
          chk("beat_data", out_data, e.data);
          chk("beat_idx", out_idx, e.idx);
          chk("beat_last", out_last, e.last);
        end
      end
      pstall = out_valid && !out_ready;
      pd = out_data;
      pi = out_idx;
    end
  end

  initial begin
    frame_t f;
    frame_t f2;
    bit     va;
    int     ia;
    bit     ok;

    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", frame_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_data", out_data, 0);

    for (int i = 0; i < N; i++)
      f[i] = 48'(longint'(i) * 65536);
    send(f, va, ia);
    chk("in_ready_drop", in_ready, 0);
    chk("first_valid", out_valid, 1);
    chk("first_idx", out_idx, 0);
    chk("first_data", out_data, 0);
    wait_idle();
    chk("cnt_one", frame_cnt, 1);

    f = rnd_frame();
    f[0] = 48'(65536);
    f[1] = 48'(98304);
    f[2] = 48'(98303);
    f[3] = -48'sd5;
    f[4] = 48'(64'd1 << 40);
    f[5] = 48'(longint'(32767) * 65536 + 32767);
    f[6] = 48'(longint'(32767) * 65536 + 32768);
    send(f, va, ia);
    wait_idle();
    chk("cnt_two", frame_cnt, 2);

    do_reset();
    rnd_ready = 1;
    for (int k = 0; k < 3; k++) begin
      send(rnd_frame(), va, ia);
      wait_idle();
    end
    chk("cnt_stall3", frame_cnt, 3);
    rnd_ready = 0;

    f  = rnd_frame();
    f2 = rnd_frame();
    send(f, va, ia);
    send(f2, va, ia);
    chk("b2b_acc_valid", va, 1);
    chk("b2b_acc_idx", ia, N - 1);
    chk("b2b_valid", out_valid, 1);
    chk("b2b_idx", out_idx, 0);
    chk("b2b_data", out_data, model(f2[0]));
    wait_idle();
    chk("cnt_b2b", frame_cnt, 5);

    send(rnd_frame(), va, ia);
    ok = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (out_valid && out_idx == 6'd20) begin
        ok = 1;
        break;
      end
    end
    chk("reach_beat20", ok, 1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    q.delete();
    chk("abort_valid", out_valid, 0);
    chk("abort_idx", out_idx, 0);
    chk("abort_cnt", frame_cnt, 0);
    chk("abort_in_ready", in_ready, 1);
    send(rnd_frame(), va, ia);
    chk("fresh_idx", out_idx, 0);
    wait_idle();
    chk("cnt_fresh", frame_cnt, 1);

    @(negedge clk);
    force dut.frame_cnt_q = 16'hFFFF;
    #1;
    release dut.frame_cnt_q;
    @(posedge clk); #1;
    chk("cnt_forced", frame_cnt, 65535);
    rnd_ready = 1;
    send(rnd_frame(), va, ia);
    wait_idle();
    chk("cnt_wrap", frame_cnt, 0);

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
